// File: rtl/controlador_elevador.sv
// rtl/controlador_elevador.sv - SCAN elevator scheduler: call latching, travel/door timing, motor and door drive
// Optional EMERGENCIA_EN adds the emergencia input and the EMERG state (estado widens to 3 bits).
module controlador_elevador #(
    parameter int N_ANDARES = 4,
    parameter int T_VIAGEM  = 4,
    parameter int T_PORTA   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_ANDARES-1:0]         chamadas,
`ifdef EMERGENCIA_EN
    input  logic                         emergencia,
    output logic [2:0]                   estado,
`else
    output logic [1:0]                   estado,
`endif
    output logic [$clog2(N_ANDARES)-1:0] andar_atual,
    output logic                         motor_sobe,
    output logic                         motor_desce,
    output logic                         porta_aberta,
    output logic [N_ANDARES-1:0]         pendentes
);

    localparam int AW   = $clog2(N_ANDARES);
    localparam int TMAX = (T_VIAGEM > T_PORTA) ? T_VIAGEM : T_PORTA;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
`ifdef EMERGENCIA_EN
    localparam int EW = 3;
    localparam logic [EW-1:0] EMERG = 3'd4;
`else
    localparam int EW = 2;
`endif
    localparam logic [EW-1:0] PARADO   = EW'(0);
    localparam logic [EW-1:0] SUBINDO  = EW'(1);
    localparam logic [EW-1:0] DESCENDO = EW'(2);
    localparam logic [EW-1:0] PORTA    = EW'(3);

    localparam logic [TW-1:0] RECARGA_VIAGEM = TW'(T_VIAGEM - 1);
    localparam logic [TW-1:0] RECARGA_PORTA  = TW'(T_PORTA - 1);
    localparam logic [N_ANDARES-1:0] UM      = N_ANDARES'(1);

    logic [TW-1:0]        timer, timer_n;
    logic                 dir, dir_n;          // 1 = up
    logic [EW-1:0]        estado_n;
    logic [AW-1:0]        andar_n, nf;
    logic [N_ANDARES-1:0] p, limpa, pend_n;
    logic                 acima, abaixo;

    function automatic logic algum_acima(input logic [N_ANDARES-1:0] m, input logic [AW-1:0] f);
        algum_acima = 1'b0;
        for (int i = 0; i < N_ANDARES; i++)
            if (i > int'(f) && m[i]) algum_acima = 1'b1;
    endfunction

    function automatic logic algum_abaixo(input logic [N_ANDARES-1:0] m, input logic [AW-1:0] f);
        algum_abaixo = 1'b0;
        for (int i = 0; i < N_ANDARES; i++)
            if (i < int'(f) && m[i]) algum_abaixo = 1'b1;
    endfunction

    // Decisions look at latched and incoming calls together so same-cycle calls are honoured.
    always_comb begin
        p        = pendentes | chamadas;
        acima    = algum_acima(p, andar_atual);
        abaixo   = algum_abaixo(p, andar_atual);
        nf       = (estado == SUBINDO) ? andar_atual + 1'b1 : andar_atual - 1'b1;
        estado_n = estado;
        andar_n  = andar_atual;
        timer_n  = timer;
        dir_n    = dir;
        limpa    = '0;

        case (estado)
            PARADO: begin
                if (p[andar_atual]) begin
                    estado_n = PORTA;
                    limpa    = UM << andar_atual;
                    timer_n  = RECARGA_PORTA;
                end else if (acima && abaixo) begin
                    estado_n = dir ? SUBINDO : DESCENDO;
                    timer_n  = RECARGA_VIAGEM;
                end else if (acima) begin
                    estado_n = SUBINDO;
                    dir_n    = 1'b1;
                    timer_n  = RECARGA_VIAGEM;
                end else if (abaixo) begin
                    estado_n = DESCENDO;
                    dir_n    = 1'b0;
                    timer_n  = RECARGA_VIAGEM;
                end
            end
            SUBINDO, DESCENDO: begin
                if (timer == '0) begin
                    andar_n = nf;
                    if (p[nf]) begin
                        estado_n = PORTA;
                        limpa    = UM << nf;
                        timer_n  = RECARGA_PORTA;
                    end else if ((estado == SUBINDO) ? algum_acima(p, nf) : algum_abaixo(p, nf)) begin
                        timer_n = RECARGA_VIAGEM;
                    end else begin
                        estado_n = PARADO;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            PORTA: begin
                // A press on the open floor is swallowed but keeps the door open longer.
                limpa = UM << andar_atual;
                if (chamadas[andar_atual])
                    timer_n = RECARGA_PORTA;
                else if (timer == '0)
                    estado_n = PARADO;
                else
                    timer_n = timer - 1'b1;
            end
            default: estado_n = PARADO;
        endcase

        pend_n = p & ~limpa;

`ifdef EMERGENCIA_EN
        if (emergencia) begin
            estado_n = EMERG;
            andar_n  = andar_atual;
            timer_n  = '0;
            dir_n    = dir;
            pend_n   = '0;
        end else if (estado == EMERG) begin
            estado_n = PARADO;
            andar_n  = andar_atual;
            timer_n  = '0;
            dir_n    = dir;
            pend_n   = '0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= PARADO;
            andar_atual  <= '0;
            pendentes    <= '0;
            timer        <= '0;
            dir          <= 1'b1;
            motor_sobe   <= 1'b0;
            motor_desce  <= 1'b0;
            porta_aberta <= 1'b0;
        end else begin
            estado       <= estado_n;
            andar_atual  <= andar_n;
            pendentes    <= pend_n;
            timer        <= timer_n;
            dir          <= dir_n;
            motor_sobe   <= (estado_n == SUBINDO);
            motor_desce  <= (estado_n == DESCENDO);
            porta_aberta <= (estado_n == PORTA);
        end
    end

endmodule

// File: tb/tb_controlador_elevador.sv
// tb/tb_controlador_elevador.sv - directed self-checking bench for controlador_elevador
module tb_controlador_elevador;

    logic       clock;
    logic       reset;
    logic [3:0] chamadas;
    logic [1:0] andar_atual;
    logic       motor_sobe, motor_desce, porta_aberta;
    logic [3:0] pendentes;
`ifdef EMERGENCIA_EN
    logic       emergencia;
    logic [2:0] estado;
`else
    logic [1:0] estado;
`endif

    int tests_run;
    int tests_failed;

    controlador_elevador #(.N_ANDARES(4), .T_VIAGEM(4), .T_PORTA(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .chamadas     (chamadas),
`ifdef EMERGENCIA_EN
        .emergencia   (emergencia),
`endif
        .estado       (estado),
        .andar_atual  (andar_atual),
        .motor_sobe   (motor_sobe),
        .motor_desce  (motor_desce),
        .porta_aberta (porta_aberta),
        .pendentes    (pendentes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        chamadas = '0;
`ifdef EMERGENCIA_EN
        emergencia = 1'b0;
`endif
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic pulse_call(input logic [3:0] c);
        chamadas = c;
        tick();
        chamadas = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({estado, andar_atual, motor_sobe, motor_desce, porta_aberta, pendentes} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: estado=%0d andar=%0d sobe=%0b desce=%0b porta=%0b pend=%b, required all 0",
                     estado, andar_atual, motor_sobe, motor_desce, porta_aberta, pendentes);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (estado !== 0 || andar_atual !== 0 || pendentes !== 0) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d: estado=%0d andar=%0d pend=%b, required 0/0/0000",
                         i, estado, andar_atual, pendentes);
            end
        end
    endtask

    task automatic test_floor0();
        int porta_cnt;
        do_reset();
        pulse_call(4'b0001);
        porta_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (porta_aberta === 1'b1) porta_cnt++;
            tests_run++;
            if (pendentes !== 4'b0000) begin
                tests_failed++;
                $display("FAIL floor0_pend cycle %0d: pend=%b, required 0000", i, pendentes);
            end
            tick();
        end
        tests_run++;
        if (porta_cnt !== 8) begin
            tests_failed++;
            $display("FAIL floor0_door_cycles: got %0d, required 8", porta_cnt);
        end
        tests_run++;
        if (estado !== 0) begin
            tests_failed++;
            $display("FAIL floor0_end_state: estado=%0d, required 0", estado);
        end
    endtask

    task automatic test_two_floor();
        int sobe_cnt, porta_cnt, exp_andar;
        do_reset();
        pulse_call(4'b0100);
        sobe_cnt  = 0;
        porta_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            exp_andar = (i < 4) ? 0 : (i < 8) ? 1 : 2;
            if (motor_sobe === 1'b1) sobe_cnt++;
            if (porta_aberta === 1'b1) porta_cnt++;
            tests_run++;
            if (andar_atual !== exp_andar[1:0]) begin
                tests_failed++;
                $display("FAIL two_floor_andar cycle %0d: got %0d, required %0d", i, andar_atual, exp_andar);
            end
            tick();
        end
        tests_run++;
        if (sobe_cnt !== 8) begin
            tests_failed++;
            $display("FAIL two_floor_motor_cycles: got %0d, required 8", sobe_cnt);
        end
        tests_run++;
        if (porta_cnt !== 8) begin
            tests_failed++;
            $display("FAIL two_floor_door_cycles: got %0d, required 8", porta_cnt);
        end
    endtask

    task automatic test_scan();
        int n;
        logic [1:0] seq[$];
        logic [1:0] exp_seq[6];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        do_reset();
        pulse_call(4'b0010);
        n = 0;
        while (estado !== 0 && n < 40) begin
            tick();
            n++;
        end
        tests_run++;
        if (n >= 40 || andar_atual !== 2'd1) begin
            tests_failed++;
            $display("FAIL scan_setup: andar=%0d after %0d cycles, required floor 1 idle", andar_atual, n);
        end
        pulse_call(4'b1001);
        seq.push_back(2'd1);
        for (int i = 0; i < 40; i++) begin
            if (andar_atual !== seq[$]) seq.push_back(andar_atual);
            tests_run++;
            if (motor_sobe === 1'b1 && motor_desce === 1'b1) begin
                tests_failed++;
                $display("FAIL scan_motors_exclusive cycle %0d: both 1, required at most one", i);
            end
            tick();
        end
        tests_run++;
        if (seq.size() != 6) begin
            tests_failed++;
            $display("FAIL scan_seq_len: got %0d floors, required 6", seq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (seq[i] !== exp_seq[i]) begin
                    tests_failed++;
                    $display("FAIL scan_seq[%0d]: got %0d, required %0d", i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_door_ext();
        int porta_cnt;
        do_reset();
        pulse_call(4'b0100);
        repeat (8) tick();
        tests_run++;
        if (porta_aberta !== 1'b1 || andar_atual !== 2'd2) begin
            tests_failed++;
            $display("FAIL door_ext_arrive: porta=%0b andar=%0d, required 1 and 2", porta_aberta, andar_atual);
        end
        repeat (6) tick();
        pulse_call(4'b0100);
        porta_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (porta_aberta === 1'b1) porta_cnt++;
            tests_run++;
            if (pendentes[2] !== 1'b0) begin
                tests_failed++;
                $display("FAIL door_ext_pend cycle %0d: pend[2]=%0b, required 0", i, pendentes[2]);
            end
            tick();
        end
        tests_run++;
        if (porta_cnt !== 8) begin
            tests_failed++;
            $display("FAIL door_ext_cycles: got %0d, required 8", porta_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_call(4'b1000);
        repeat (5) tick();
        tests_run++;
        if (motor_sobe !== 1'b1 || andar_atual !== 2'd1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: sobe=%0b andar=%0d, required 1 and 1", motor_sobe, andar_atual);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (andar_atual !== 0 || motor_sobe !== 0 || pendentes !== 0 || estado !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: andar=%0d sobe=%0b pend=%b estado=%0d, required all 0",
                     andar_atual, motor_sobe, pendentes, estado);
        end
        tick();
        reset = 1'b1;
    endtask

`ifdef EMERGENCIA_EN
    task automatic test_emergencia();
        do_reset();
        pulse_call(4'b1000);
        repeat (5) tick();
        emergencia = 1'b1;
        tick();
        tests_run++;
        if (estado !== 3'd4 || motor_sobe !== 0 || motor_desce !== 0 || andar_atual !== 2'd1 || pendentes !== 0) begin
            tests_failed++;
            $display("FAIL emerg_enter: estado=%0d sobe=%0b desce=%0b andar=%0d pend=%b, required 4/0/0/1/0000",
                     estado, motor_sobe, motor_desce, andar_atual, pendentes);
        end
        chamadas = 4'b0001;
        repeat (3) tick();
        tests_run++;
        if (pendentes !== 0 || estado !== 3'd4) begin
            tests_failed++;
            $display("FAIL emerg_ignore: pend=%b estado=%0d, required 0000 and 4", pendentes, estado);
        end
        chamadas   = '0;
        emergencia = 1'b0;
        tick();
        tests_run++;
        if (estado !== 0 || andar_atual !== 2'd1) begin
            tests_failed++;
            $display("FAIL emerg_exit: estado=%0d andar=%0d, required 0 and 1", estado, andar_atual);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        chamadas     = '0;
`ifdef EMERGENCIA_EN
        emergencia   = 1'b0;
`endif
        test_reset();
        test_floor0();
        test_two_floor();
        test_scan();
        test_door_ext();
        test_reset_mid();
`ifdef EMERGENCIA_EN
        test_emergencia();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/controlador_elevador.md
Name: controlador_elevador

Overview:
- Scheduler for the car's floor-call register bank.
- Latches per-floor call buttons into a pending mask, one set/reset bit per floor.
- Chooses travel direction with a SCAN policy, times floor-to-floor travel and door dwell, and drives the motor and door outputs.
- Sits between the floor button inputs and the motor/door drivers of the elevator system.

Parameters:
- N_ANDARES, 4: number of floors; valid range 2..8.
- T_VIAGEM, 4: clock cycles to travel one floor; must be ≥1.
- T_PORTA, 8: clock cycles the door stays open; must be ≥1.

Ports:
- clock  input  1: single system clock; rising edge.
- reset  input  1: asynchronous, active-low reset.
- chamadas  input  N_ANDARES: floor call buttons, one bit per floor; level or pulse, sampled every edge.
- andar_atual  output  $clog2(N_ANDARES): current floor index.
- motor_sobe  output  1: motor drives the car up.
- motor_desce  output  1: motor drives the car down.
- porta_aberta  output  1: door open.
- pendentes  output  N_ANDARES: registered pending-call mask.
- estado  output  2: FSM state; PARADO=0, SUBINDO=1, DESCENDO=2, PORTA=3.

Behaviour:
- Reset (reset=0, asynchronous) forces the following values:
  - estado=PARADO, andar_atual=0, pendentes=0.
  - motor_sobe=0, motor_desce=0, porta_aberta=0.
  - Internal timer=0, direction register dir=up.
  - Reset mid-travel or mid-door abandons the operation immediately; pending calls are lost.
- All outputs are registered and derive from the state register:
  - motor_sobe=1 only in SUBINDO.
  - motor_desce=1 only in DESCENDO.
  - porta_aberta=1 only in PORTA.
  - motor_sobe and motor_desce are never both 1.
- Pending mask update, every edge: pendentes <= (pendentes | chamadas) & ~limpa.
  - limpa is the one-hot bit of the floor being served this cycle.
  - Clear wins over a simultaneous set on the same bit.
- Let p = pendentes | chamadas. This combined view is used for every decision, so a call arriving in the same cycle as a decision is honoured.
  - acima = any bit of p above andar_atual.
  - abaixo = any bit of p below andar_atual.
  - aqui = p[andar_atual].
- PARADO, evaluated in priority order:
  - aqui -> PORTA; clear that bit; timer=T_PORTA-1.
  - Else if acima and abaixo: go to SUBINDO if dir=up, otherwise DESCENDO.
  - Else acima -> SUBINDO, dir=up.
  - Else abaixo -> DESCENDO, dir=down.
  - Else stay in PARADO.
  - On entering SUBINDO or DESCENDO, timer=T_VIAGEM-1.
- SUBINDO / DESCENDO:
  - Timer decrements each cycle.
  - When timer=0: andar_atual increments (SUBINDO) or decrements (DESCENDO) by 1.
  - On that same edge, evaluate p for the new floor:
    - Call on the new floor -> PORTA; clear its bit; timer=T_PORTA-1.
    - Else a call further in the same direction -> remain in the state; timer=T_VIAGEM-1.
    - Else -> PARADO.
- Floor bounds:
  - andar_atual never leaves 0..N_ANDARES-1.
  - SUBINDO is never entered at the top floor, DESCENDO never at floor 0; this follows from acima/abaixo being false there.
- PORTA:
  - Timer decrements; timer=0 -> PARADO.
  - A call to andar_atual during PORTA is not latched (the bit is cleared that cycle) and reloads the timer to T_PORTA-1, extending the dwell.
  - Calls to other floors are latched normally.
- Latency:
  - A call is visible on pendentes one edge after it is sampled.
  - From PARADO, motion starts on the edge that samples the call.
  - A one-floor trip takes T_VIAGEM cycles in motion.
- Stuck-on button: a call held high continuously on the current floor keeps the door open indefinitely. This is accepted behaviour.

Optional Feature:
- Macro: EMERGENCIA_EN.
- When defined:
  - Adds input port emergencia (1 bit, active-high, synchronous) and a fifth state EMERG; estado widens to 3 bits with EMERG=4.
  - emergencia=1 in any state -> EMERG on the next edge: motors 0, porta_aberta=0, pendentes cleared, chamadas ignored.
  - emergencia=0 -> PARADO on the next edge; andar_atual is retained.
  - emergencia takes precedence over every other transition.
- When undefined: no emergencia port, estado is 2 bits, and no EMERG logic exists.

Test Plan:
- Reset with chamadas=0 -> all outputs 0 and estado=0; no state change for 20 cycles.
- Floor-0 call:
  - At floor 0, PARADO, pulse chamadas=4'b0001 for 1 cycle.
  - Required: porta_aberta=1 for exactly 8 cycles, then PARADO; pendentes=0 throughout.
- Two-floor trip:
  - At floor 0, pulse chamadas=4'b0100.
  - Required: motor_sobe=1 for 8 cycles, andar_atual steps 0->1->2 every 4 cycles, then porta_aberta=1 for 8 cycles.
- SCAN ordering:
  - At floor 1 with dir=up, set calls for floors 3 and 0 together.
  - Required: serves floor 3 first, then descends to floor 0; andar_atual sequence 1,2,3,2,1,0.
- Door extension:
  - During PORTA at floor 2, pulse chamadas[2] with timer=1.
  - Required: door stays open 8 more cycles and pendentes[2] stays 0.
- Reset mid-travel:
  - Assert reset while SUBINDO between floors 1 and 2.
  - Required: immediately andar_atual=0, motor_sobe=0, pendentes=0.
  - With EMERGENCIA_EN defined, a second run raises emergencia mid-travel. Required: estado=4 and motors 0 the next cycle, and andar_atual is held.
